// File: rtl/mdu.sv
/*==========================================================================
 * Module   : mdu
 * Brief    : Multi-cycle multiply/divide unit with HI/LO registers.
 *            Optional macro MDU_CANCEL_EN adds a cancel input that aborts
 *            an in-flight operation.
 * Revision : 1.0
 *==========================================================================*/
`default_nettype none

module mdu #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  multctrl,
    input  logic [1:0]  muwe,
    input  logic [1:0]  mure,
    input  logic [31:0] a,
    input  logic [31:0] b,
`ifdef MDU_CANCEL_EN
    input  logic        cancel,
`endif
    output logic        busy,
    output logic [31:0] out
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t             state;
    state_t             state_next;
    logic [CNT_W-1:0]   count;
    logic [2:0]         op_q;
    logic [31:0]        a_q;
    logic [31:0]        b_q;
    logic [31:0]        hi;
    logic [31:0]        lo;

    logic               cancel_req;
    logic               op_valid;
    logic               launch;
    logic               finish;
    logic               write_hi;
    logic               write_lo;

`ifdef MDU_CANCEL_EN
    assign cancel_req = cancel;
`else
    assign cancel_req = 1'b0;
`endif

    assign op_valid = (multctrl == OP_MULT) || (multctrl == OP_MULTU) ||
                      (multctrl == OP_DIV)  || (multctrl == OP_DIVU);

    // Control FSM: start takes priority over muwe; both are ignored in BUSY.
    always_comb begin
        state_next = state;
        launch     = 1'b0;
        finish     = 1'b0;
        write_hi   = 1'b0;
        write_lo   = 1'b0;
        case (state)
            IDLE: begin
                if (!cancel_req) begin
                    if (start && op_valid) begin
                        launch     = 1'b1;
                        state_next = BUSY;
                    end else begin
                        write_hi = (muwe == 2'd1);
                        write_lo = (muwe == 2'd2);
                    end
                end
            end
            BUSY: begin
                if (cancel_req) begin
                    state_next = IDLE;
                end else if (count == CNT_W'(1)) begin
                    finish     = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Arithmetic on the latched operands; the result is only consumed on the
    // finishing edge, so the wide combinational paths have N cycles of slack.
    logic        is_div;
    logic        is_signed;
    logic [63:0] prod;
    logic        a_neg;
    logic        b_neg;
    logic [31:0] a_mag;
    logic [31:0] b_mag;
    logic [31:0] q_mag;
    logic [31:0] r_mag;
    logic [31:0] res_hi;
    logic [31:0] res_lo;

    assign is_div    = (op_q == OP_DIV) || (op_q == OP_DIVU);
    assign is_signed = (op_q == OP_DIV) || (op_q == OP_MULT);

    always_comb begin
        prod   = 64'd0;
        a_neg  = is_signed & a_q[31];
        b_neg  = is_signed & b_q[31];
        a_mag  = a_neg ? (32'd0 - a_q) : a_q;
        b_mag  = b_neg ? (32'd0 - b_q) : b_q;
        q_mag  = 32'd0;
        r_mag  = 32'd0;
        res_hi = 32'd0;
        res_lo = 32'd0;
        if (is_div) begin
            // Magnitude division avoids the signed INT_MIN / -1 overflow case.
            if (b_mag != 32'd0) begin
                q_mag = a_mag / b_mag;
                r_mag = a_mag % b_mag;
            end
            res_lo = (a_neg ^ b_neg) ? (32'd0 - q_mag) : q_mag;
            res_hi = a_neg ? (32'd0 - r_mag) : r_mag;
        end else begin
            if (is_signed) begin
                prod = {{32{a_q[31]}}, a_q} * {{32{b_q[31]}}, b_q};
            end else begin
                prod = {32'd0, a_q} * {32'd0, b_q};
            end
            res_hi = prod[63:32];
            res_lo = prod[31:0];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
            op_q  <= 3'd0;
            a_q   <= 32'd0;
            b_q   <= 32'd0;
            hi    <= 32'd0;
            lo    <= 32'd0;
        end else begin
            if (launch) begin
                op_q  <= multctrl;
                a_q   <= a;
                b_q   <= b;
                count <= ((multctrl == OP_DIV) || (multctrl == OP_DIVU)) ?
                         CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
            end else if (state == BUSY) begin
                count <= cancel_req ? '0 : (count - CNT_W'(1));
            end
            if (write_hi) begin
                hi <= a;
            end
            if (write_lo) begin
                lo <= a;
            end
            if (finish && !(is_div && (b_q == 32'd0))) begin
                hi <= res_hi;
                lo <= res_lo;
            end
        end
    end

    assign busy = (state == BUSY);

    always_comb begin
        case (mure)
            2'd1:    out = hi;
            2'd2:    out = lo;
            default: out = 32'd0;
        endcase
    end

endmodule

`default_nettype wire

// File: tb/tb_mdu.sv
/*==========================================================================
 * Module   : tb_mdu
 * Brief    : Directed self-checking bench for mdu.
 * Revision : 1.0
 *==========================================================================*/
`default_nettype none

module tb_mdu;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [2:0]  multctrl;
    logic [1:0]  muwe;
    logic [1:0]  mure;
    logic [31:0] a;
    logic [31:0] b;
    logic        cancel;
    logic        busy;
    logic [31:0] out;

    int total = 0;
    int bad   = 0;

    mdu #(
        .MULT_CYCLES(5),
        .DIV_CYCLES (10)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .multctrl(multctrl),
        .muwe    (muwe),
        .mure    (mure),
        .a       (a),
        .b       (b),
`ifdef MDU_CANCEL_EN
        .cancel  (cancel),
`endif
        .busy    (busy),
        .out     (out)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%08h expected=%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_hilo(input string tag, input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        mure = 2'd1;
        #1;
        check({tag, "_hi"}, out, exp_hi);
        mure = 2'd2;
        #1;
        check({tag, "_lo"}, out, exp_lo);
        mure = 2'd0;
    endtask

    task automatic issue(input logic [2:0] op, input logic [31:0] aa, input logic [31:0] bb);
        multctrl = op;
        a        = aa;
        b        = bb;
        start    = 1'b1;
        tick();
        start    = 1'b0;
        multctrl = 3'd0;
        a        = 32'hA5A5A5A5;
        b        = 32'h5A5A5A5A;
    endtask

    task automatic mtx(input logic [1:0] which, input logic [31:0] val);
        muwe = which;
        a    = val;
        tick();
        muwe = 2'd0;
    endtask

    // Counts busy cycles from the current one until idle, bounded.
    task automatic wait_idle(output int n);
        n = 0;
        while (busy && n < 100) begin
            n++;
            tick();
        end
    endtask

    int n;

    initial begin
        reset = 1'b1; start = 1'b0; multctrl = 3'd0; muwe = 2'd0;
        mure = 2'd0; a = 32'd0; b = 32'd0; cancel = 1'b0;
        tick(); tick();
        reset = 1'b0;
        check("rst_busy", {31'd0, busy}, 32'd0);
        chk_hilo("rst", 32'd0, 32'd0);

        // mthi then read back next cycle
        mtx(2'd1, 32'hDEADBEEF);
        chk_hilo("mthi", 32'hDEADBEEF, 32'd0);

        // mult signed; out holds pre-op value during BUSY
        issue(3'd1, 32'hFFFFFFFE, 32'd3);
        check("mult_busy", {31'd0, busy}, 32'd1);
        chk_hilo("mult_pre", 32'hDEADBEEF, 32'd0);
        wait_idle(n);
        check("mult_cyc", n, 32'd5);
        chk_hilo("mult", 32'hFFFFFFFF, 32'hFFFFFFFA);

        issue(3'd2, 32'hFFFFFFFF, 32'd2);
        wait_idle(n);
        check("multu_cyc", n, 32'd5);
        chk_hilo("multu", 32'h00000001, 32'hFFFFFFFE);

        issue(3'd3, 32'hFFFFFFF9, 32'd2);
        wait_idle(n);
        check("div_cyc", n, 32'd10);
        chk_hilo("div", 32'hFFFFFFFF, 32'hFFFFFFFD);

        // divide by zero leaves HI/LO; mtlo and start during BUSY ignored
        mtx(2'd1, 32'h12345678);
        mtx(2'd2, 32'h12345678);
        issue(3'd4, 32'd7, 32'd0);
        muwe = 2'd2; a = 32'hAAAAAAAA; start = 1'b1; multctrl = 3'd1;
        tick();
        muwe = 2'd0; start = 1'b0; multctrl = 3'd0;
        wait_idle(n);
        check("divz_cyc", n, 32'd9);
        chk_hilo("divz", 32'h12345678, 32'h12345678);

        issue(3'd3, 32'h80000000, 32'hFFFFFFFF);
        wait_idle(n);
        chk_hilo("divovf", 32'd0, 32'h80000000);

        issue(3'd4, 32'd100, 32'd7);
        wait_idle(n);
        chk_hilo("divu", 32'd2, 32'd14);

        // invalid op codes are ignored
        multctrl = 3'd5; start = 1'b1; tick();
        check("op5_busy", {31'd0, busy}, 32'd0);
        multctrl = 3'd0; tick();
        start = 1'b0;
        check("op0_busy", {31'd0, busy}, 32'd0);
        chk_hilo("inv", 32'd2, 32'd14);

        // start and muwe together: start wins
        multctrl = 3'd4; a = 32'd100; b = 32'd9; start = 1'b1; muwe = 2'd1;
        tick();
        start = 1'b0; muwe = 2'd0; multctrl = 3'd0;
        check("sw_busy", {31'd0, busy}, 32'd1);
        chk_hilo("sw_pre", 32'd2, 32'd14);
        wait_idle(n);
        chk_hilo("sw", 32'd1, 32'd11);

        mure = 2'd3; #1;
        check("mure3", out, 32'd0);
        mure = 2'd0;

        // reset at 3rd busy cycle
        issue(3'd1, 32'd6, 32'd7);
        tick(); tick();
        check("rb_busy", {31'd0, busy}, 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("rb_idle", {31'd0, busy}, 32'd0);
        chk_hilo("rb", 32'd0, 32'd0);
        tick(); tick(); tick(); tick(); tick();
        chk_hilo("rb_late", 32'd0, 32'd0);

`ifdef MDU_CANCEL_EN
        mtx(2'd1, 32'h11112222);
        mtx(2'd2, 32'h33334444);
        issue(3'd3, 32'd9, 32'd3);
        tick();
        cancel = 1'b1;
        tick();
        cancel = 1'b0;
        check("cn_busy", {31'd0, busy}, 32'd0);
        tick(); tick(); tick(); tick(); tick(); tick(); tick(); tick(); tick();
        chk_hilo("cn", 32'h11112222, 32'h33334444);
        cancel = 1'b1; start = 1'b1; multctrl = 3'd1; muwe = 2'd1; a = 32'd5; b = 32'd5;
        tick();
        cancel = 1'b0; start = 1'b0; multctrl = 3'd0; muwe = 2'd0;
        check("cn_idle_busy", {31'd0, busy}, 32'd0);
        chk_hilo("cn_idle", 32'h11112222, 32'h33334444);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
